sm_dot_accum: RTL and testbench

Streaming sign-magnitude dot-product accumulator. It sits directly downstream of the two's-complement to sign-magnitude converters in the integer datapath. Each cycle it accepts one pair of DW-bit sign-magnitude operands, multiplies the magnitudes, restores two's complement, and accumulates the result. At a group boundary marked by `in_last` it emits one signed sum.

---
 rtl/sm_dot_accum_pkg.sv | 17 +
 rtl/sm_dot_accum_if.sv | 29 ++
 rtl/sm_twos_convert.sv | 16 +
 rtl/sm_dot_accum.sv | 155 +++++++++++++++
 tb/tb_sm_dot_accum.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sm_dot_accum_pkg.sv
// Shared constants and the stage-1 pipeline record for sm_dot_accum.
// The S1 record width is fixed by DW_DEF, so the top must be built with DW == DW_DEF.
package sm_dot_pkg;

  localparam int DW_DEF = 9;
  localparam int AW_DEF = 32;
  localparam int CW_DEF = 16;
  localparam int PW     = 2 * DW_DEF - 1;

  typedef struct packed {
    logic [PW-1:0] p;
    logic          s;
    logic          last;
    logic          valid;
  } s1_rec_t;

endpackage

// File: rtl/sm_dot_accum_if.sv
// Operand-in / result-out stream bundle for sm_dot_accum.
interface sm_dot_accum_if #(
  parameter int DW = 9,
  parameter int AW = 32,
  parameter int CW = 16
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          out_sat;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_sat
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_count, out_sat
  );

endinterface

// File: rtl/sm_twos_convert.sv
// Sign plus unsigned magnitude to sign-extended AW-bit two's complement.
module sm_twos_convert #(
  parameter int PW = 17,
  parameter int AW = 32
) (
  input  logic                 s_i,
  input  logic [PW-1:0]        p_i,
  output logic signed [AW-1:0] v_o
);

  logic signed [AW-1:0] mag;

  assign mag = {{(AW-PW){1'b0}}, p_i};
  assign v_o = s_i ? -mag : mag;

endmodule

// File: rtl/sm_dot_accum.sv
// Streaming sign-magnitude dot-product accumulator, one signed sum per group.
// Define SM_DOT_ACC_SAT_EN to clamp every add and report a sticky per-group out_sat.
module sm_dot_accum
  import sm_dot_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int CW = CW_DEF
) (
  input logic           clk,
  input logic           rst,
  sm_dot_accum_if.slave bus
);

  // Sign bit with zero magnitude encodes the most-negative value -2^(DW-1).
  function automatic logic [PW-1:0] dec_mag(input logic [DW-1:0] x);
    logic [PW-1:0] m;
    if (x[DW-1] && (x[DW-2:0] == '0)) m = {{(PW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
    else                               m = {{(PW-DW+1){1'b0}}, x[DW-2:0]};
    return m;
  endfunction

`ifdef SM_DOT_ACC_SAT_EN
  // Returns {clamped, result}; overflow shows as disagreement of the two top bits.
  function automatic logic [AW:0] sat_add(input logic signed [AW-1:0] a,
                                          input logic signed [AW-1:0] b);
    logic signed [AW:0] wide;
    logic [AW:0]        r;
    wide = {a[AW-1], a} + {b[AW-1], b};
    if (wide[AW] != wide[AW-1])
      r = {1'b1, wide[AW], {(AW-1){~wide[AW]}}};
    else
      r = {1'b0, wide[AW-1:0]};
    return r;
  endfunction
`endif

  logic                 stall;
  logic [PW-1:0]        ma, mb;
  s1_rec_t              s1_d, s1_q;
  logic signed [AW-1:0] v;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] acc_d, acc_q;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic                 out_valid_d, out_valid_q;
  logic [AW-1:0]        out_data_d, out_data_q;
  logic [CW-1:0]        out_count_d, out_count_q;

  assign stall        = out_valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Stage 1: magnitude product and product sign
  assign ma = dec_mag(bus.in_a);
  assign mb = dec_mag(bus.in_b);

  always_comb begin
    s1_d       = s1_q;
    s1_d.p     = ma * mb;
    s1_d.s     = bus.in_a[DW-1] ^ bus.in_b[DW-1];
    s1_d.last  = bus.in_last;
    s1_d.valid = bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (rst)         s1_q.valid <= 1'b0;
    else if (!stall) s1_q       <= s1_d;
  end

  // Stage 2: restore two's complement, accumulate, emit on last
  sm_twos_convert #(.PW(PW), .AW(AW)) u_cvt (
    .s_i (s1_q.s),
    .p_i (s1_q.p),
    .v_o (v)
  );

`ifdef SM_DOT_ACC_SAT_EN
  logic clamp;
  logic sat_d, sat_q;
  logic out_sat_d, out_sat_q;

  assign {clamp, sum} = sat_add(acc_q, v);
  assign bus.out_sat  = out_sat_q;

  always_comb begin
    sat_d     = sat_q;
    out_sat_d = out_sat_q;
    if (!stall && s1_q.valid) begin
      if (s1_q.last) begin
        out_sat_d = sat_q | clamp;
        sat_d     = 1'b0;
      end else begin
        sat_d     = sat_q | clamp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q     <= 1'b0;
      out_sat_q <= 1'b0;
    end else begin
      sat_q     <= sat_d;
      out_sat_q <= out_sat_d;
    end
  end
`else
  assign sum         = acc_q + v;
  assign bus.out_sat = 1'b0;
`endif

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (!stall) begin
      // Not stalled means any held result is being accepted this cycle.
      out_valid_d = 1'b0;
      if (s1_q.valid) begin
        if (s1_q.last) begin
          out_data_d  = sum;
          out_count_d = cnt_q + CW'(1);
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d       = sum;
          cnt_d       = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_sm_dot_accum.sv
// Randomized and directed bench for sm_dot_accum against an integer group-sum model.
module tb_sm_dot_accum;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sm_dot_accum_if #(.DW(9), .AW(32), .CW(16)) bus ();
  sm_dot_accum_if #(.DW(9), .AW(18), .CW(16)) sbus ();

  sm_dot_accum #(.DW(9), .AW(32), .CW(16)) dut   (.clk(clk), .rst(rst), .bus(bus.slave));
  sm_dot_accum #(.DW(9), .AW(18), .CW(16)) dut_s (.clk(clk), .rst(rst), .bus(sbus.slave));

  typedef struct {
    longint data;
    longint cnt;
    longint sat;
  } exp_t;

  exp_t   exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;
  longint m_acc = 0;
  longint m_cnt = 0;
  int     run = 0;
  int     maxrun = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint dec(input logic [8:0] x);
    longint m;
    m = longint'(x[7:0]);
    if (x[8] && m == 0) return -256;
    return x[8] ? -m : m;
  endfunction

  function automatic longint wrap32(input longint x);
    logic signed [31:0] t;
    t = x[31:0];
    return longint'(t);
  endfunction

  function automatic logic [8:0] rand_op();
    logic [8:0] r;
    if ($urandom_range(7) == 0) r = 9'h100;
    else r = 9'($urandom_range(511));
    return r;
  endfunction

  // Present one pair until accepted; the model absorbs it on acceptance.
  task automatic send(input logic [8:0] a, input logic [8:0] b, input logic last,
                      input int rdy_pct);
    bit acc;
    int n;
    exp_t e;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_last   = last;
      bus.out_ready = ($urandom_range(99) < rdy_pct);
      #1 acc = bus.in_ready;
      @(posedge clk);
      n++;
    end
    if (!acc) check("send_timeout", 0, 1);
    m_acc += dec(a) * dec(b);
    m_cnt++;
    if (last) begin
      e.data = wrap32(m_acc);
      e.cnt  = m_cnt % 65536;
      e.sat  = 0;
      exp_q.push_back(e);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  task automatic idle(input int n, input int rdy_pct);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = ($urandom_range(99) < rdy_pct);
      @(posedge clk);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      idle(1, 100);
      n++;
    end
    if (exp_q.size() > 0) check("drain_timeout", exp_q.size(), 0);
    idle(1, 100);
  endtask

  // Result monitor: every accepted result is checked against the queue head.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus.out_valid && bus.out_ready) begin
      run++;
      if (exp_q.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", longint'($signed(bus.out_data)), e.data);
        check("out_count", longint'(bus.out_count), e.cnt);
        check("out_sat", longint'(bus.out_sat), e.sat);
      end
    end else begin
      run = 0;
    end
    if (run > maxrun) maxrun = run;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint     s_exp;
    longint     s_sat;
    int         n;
    int         len;
    logic [8:0] a, b;

    rst = 1'b1;
    bus.in_valid = 1'b0;  bus.in_a = '0;  bus.in_b = '0;  bus.in_last = 1'b0;
    bus.out_ready = 1'b0;
    sbus.in_valid = 1'b0; sbus.in_a = '0; sbus.in_b = '0; sbus.in_last = 1'b0;
    sbus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", longint'(bus.out_data), 0);
    check("rst_out_count", longint'(bus.out_count), 0);
    check("rst_out_sat", bus.out_sat, 0);
    rst = 1'b0;

    // Signed product with latency check
    send(9'h105, 9'h003, 1'b1, 100);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    #1 check("lat_edge1_valid", bus.out_valid, 0);
    @(negedge clk);
    #1 check("lat_edge2_valid", bus.out_valid, 1);
    check("lat_data", longint'($signed(bus.out_data)), -15);
    drain();

    // Most-negative code
    send(9'h100, 9'h100, 1'b1, 100);
    send(9'h100, 9'h001, 1'b1, 100);
    drain();

    // Four-element group
    send(9'h003, 9'h004, 1'b0, 100);
    send(9'h102, 9'h007, 1'b0, 100);
    send(9'h000, 9'h05A, 1'b0, 100);
    send(9'h0FF, 9'h1FF, 1'b1, 100);
    drain();

    // Back-pressure: result held for 5 cycles with the next pair waiting
    send(9'h007, 9'h106, 1'b1, 100);
    idle(1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.in_a = 9'h002; bus.in_b = 9'h002; bus.in_last = 1'b1;
      bus.out_ready = 1'b0;
      #1;
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_out_data", longint'($signed(bus.out_data)), -42);
      @(posedge clk);
    end
    send(9'h002, 9'h002, 1'b1, 100);
    drain();

    // Back-to-back single-element groups
    maxrun = 0;
    for (int i = 0; i < 6; i++) begin
      a = {1'($urandom_range(1)), 8'($urandom_range(1, 255))};
      b = {1'($urandom_range(1)), 8'($urandom_range(1, 255))};
      send(a, b, 1'b1, 100);
    end
    drain();
    check("b2b_run", longint'(maxrun >= 6), 1);

    // Saturation on the AW=18 instance: two 9'h100*9'h100 elements
    s_exp = 0;
    s_sat = 0;
    for (int i = 0; i < 2; i++) begin
      s_exp += 65536;
`ifdef SM_DOT_ACC_SAT_EN
      if (s_exp > 131071) begin s_exp = 131071; s_sat = 1; end
`else
      if (s_exp > 131071) s_exp -= 262144;
`endif
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sbus.in_valid = 1'b1; sbus.in_a = 9'h100; sbus.in_b = 9'h100;
      sbus.in_last = (i == 1);
      @(posedge clk);
    end
    @(negedge clk);
    sbus.in_valid = 1'b0; sbus.in_last = 1'b0;
    n = 0;
    #1;
    while (!sbus.out_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("sat_valid", sbus.out_valid, 1);
    check("sat_data", longint'($signed(sbus.out_data)), s_exp);
    check("sat_flag", sbus.out_sat, s_sat);

    // Reset mid-group, then a fresh group
    send(9'h001, 9'h002, 1'b0, 100);
    send(9'h003, 9'h001, 1'b0, 100);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_data", longint'(bus.out_data), 0);
    check("mid_rst_out_count", longint'(bus.out_count), 0);
    check("mid_rst_in_ready", bus.in_ready, 1);
    rst = 1'b0;
    m_acc = 0;
    m_cnt = 0;
    send(9'h002, 9'h003, 1'b1, 100);
    drain();

    // Randomized groups with random stalls and gaps
    for (int g = 0; g < 40; g++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        send(rand_op(), rand_op(), (k == len - 1), 70);
        if ($urandom_range(3) == 0) idle($urandom_range(1, 2), 70);
      end
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
